spi_slave: RTL
==============

Name: spi_slave

Overview:
- SPI slave endpoint for the SPI master block; responds to an external or on-chip master on SCLK/MOSI/SS_N and returns data on MISO.
- Bus timing mirrors the master: mode 0, MSB first, variable-length frames.
- Bus pins are synchronised into the clk domain and edge-detected.
- The host side gets a buffered TX word and an RX word plus bit count per frame.

Parameters:
- SPI_MAXLEN, 32, maximum bits per frame and width of the data ports.
- SYNC_STAGES, 2, flip-flop stages on SCLK, MOSI and SS_N; minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- tx_load  input  1  one-cycle strobe; captures tx_data/tx_nbits into the TX buffer
- tx_data  input  SPI_MAXLEN  response word; bit tx_nbits-1 is sent first
- tx_nbits  input  $clog2(SPI_MAXLEN)+1  number of valid response bits
- rx_data  output  SPI_MAXLEN  last received frame, right-aligned, last bit in [0]
- rx_nbits  output  $clog2(SPI_MAXLEN)+1  SCLK rising edges in the last frame, saturating at SPI_MAXLEN
- rx_valid  output  1  frame-complete flag; held until acknowledged
- rx_ack  input  1  clears rx_valid
- busy  output  1  high while a frame is in progress
- SCLK  input  1  SPI clock from the master
- MOSI  input  1  master-out data
- SS_N  input  1  slave select, active-low
- MISO  output  1  slave-out data

Behaviour:
- Timing constraints on the master:
  - SCLK high and low times are each at least SYNC_STAGES+2 clk cycles.
  - The time from SS_N falling to the first SCLK rise is at least SYNC_STAGES+2 clk cycles.
- All three bus inputs pass through identical SYNC_STAGES synchronisers, so MOSI stays aligned with SCLK.
- Edge detection uses the synchronised value against its registered previous value.
- States:
  - IDLE: waiting for the synchronised SS_N to fall; move to ACTIVE.
  - ACTIVE: shifting; synchronised SS_N rising returns to IDLE and completes the frame.
  - WAIT_IDLE: entered after reset; stay until synchronised SS_N = 1, then go to IDLE. A frame already in progress at reset is never captured.
- Reset values:
  - rx_data = 0, rx_nbits = 0, rx_valid = 0, busy = 0, MISO = 0.
  - TX buffer cleared: data 0, nbits 0.
  - Synchroniser flops reset to 1 for SS_N and 0 for SCLK/MOSI.
- TX buffer:
  - Written on any tx_load, including while ACTIVE.
  - The frame in flight uses the copy captured at its SS_N fall; a mid-frame load only affects the next frame.
- SS_N fall (IDLE to ACTIVE):
  - Copy the TX buffer into the TX shifter and set the TX index to tx_nbits-1.
  - Drive MISO = tx_data[tx_nbits-1] on the next clk edge, or 0 if tx_nbits = 0.
  - busy goes to 1 on the same edge.
  - Clear the RX shifter and bit counter.
- SCLK rise (ACTIVE only):
  - rx_shift <= {rx_shift[SPI_MAXLEN-2:0], MOSI_sync}.
  - The counter increments, saturating at SPI_MAXLEN.
  - If more than SPI_MAXLEN bits arrive, the last SPI_MAXLEN bits are kept.
- SCLK fall (ACTIVE only):
  - Decrement the TX index and drive the next bit.
  - Once the index is exhausted, MISO = 0 for the rest of the frame.
  - MISO changes SYNC_STAGES+1 clk cycles after the pin-level SCLK fall.
- SS_N rise (ACTIVE to IDLE):
  - rx_data <= rx_shift, rx_nbits <= counter, rx_valid <= 1, busy <= 0, MISO <= 0.
  - A frame with zero clocks still completes, with rx_nbits = 0 and rx_data = 0.
- rx_data/rx_nbits stay stable until the next frame completes.
- rx_ack clears rx_valid the next cycle. If rx_ack coincides with frame completion, the set wins.
- SCLK edges seen while in IDLE or WAIT_IDLE are ignored.
- Simultaneous synchronised SCLK edge and SS_N rise: SS_N rise takes priority, and the SCLK edge is discarded.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- When defined:
  - Adds output port rx_overrun (1 bit, reset 0).
  - rx_overrun is a sticky flag, set when a frame completes while rx_valid is already 1 and no rx_ack arrives in that same cycle.
  - rx_data is still overwritten by the new frame.
  - The flag is cleared only by rx_ack.
- When undefined: the port and logic are absent, and overwrite is silent.

Test Plan:
- Basic exchange, SCLK = clk/8, tx_load with tx_data=0xA5, tx_nbits=8; master sends 8 bits 0x3C:
  - Master receives 0xA5.
  - rx_data = 0x0000003C, rx_nbits = 8, rx_valid = 1, busy toggles 0→1→0.
- Short response: tx_nbits=4, tx_data=0xF; master clocks 12 bits of 0xABC:
  - MISO bit sequence is 1111 then 0000 0000.
  - rx_data = 0xABC, rx_nbits = 12.
- Overlong frame: master clocks 40 bits with SPI_MAXLEN=32:
  - rx_nbits = 32.
  - rx_data = the last 32 MOSI bits.
- Mid-frame tx_load: load 0x11 before the frame and 0x22 during it:
  - The current frame returns 0x11.
  - The next frame returns 0x22.
- Reset during a frame: assert rst after bit 3 of an 8-bit frame:
  - No rx_valid for that frame; outputs hold at reset values.
  - The next full frame 0x5A is received correctly.
- Overrun (SPI_SLAVE_OVERRUN_EN defined): two frames 0x01 then 0x02 with no rx_ack:
  - rx_overrun = 1, rx_data = 0x02.
  - rx_ack clears both rx_overrun and rx_valid.
  - With the macro undefined, rx_data = 0x02 and no flag exists.

Source files
------------

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave -- SPI mode-0 slave endpoint, MSB first, variable-length frames.
//
// The bus pins (SCLK, MOSI, SS_N) are sampled through identical SYNC_STAGES
// flop chains into the clk domain and edge-detected there.
// The host loads a response word into a TX buffer. After each frame it gets
// the received word, right-aligned, plus the number of SCLK rising edges.
//
// Optional feature: define SPI_SLAVE_OVERRUN_EN to add the sticky
// rx_overrun output. Without it, an unread frame is silently overwritten.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   tx_load        1-cycle strobe, captures tx_data/tx_nbits into TX buffer
//   tx_data        response word, bit tx_nbits-1 goes out first
//   tx_nbits       number of valid response bits
//   rx_data        last received frame, last bit in [0]
//   rx_nbits       SCLK rises in last frame, saturating at SPI_MAXLEN
//   rx_valid       frame-complete flag, held until rx_ack
//   rx_ack         clears rx_valid
//   busy           high while a frame is in progress
//   SCLK/MOSI/SS_N SPI bus inputs from the master
//   MISO           slave-out data (registered)
//   rx_overrun     (SPI_SLAVE_OVERRUN_EN only) sticky overwrite flag
//
// Handshake: rx_valid is set on the edge that completes a frame and stays
// high until a cycle with rx_ack=1 has been seen. It then drops on the next
// edge. If completion and rx_ack land in the same cycle, rx_valid stays set.
// tx_load has no ready: it is accepted in every cycle.
// ---------------------------------------------------------------------------
module spi_slave #(
   parameter int SPI_MAXLEN  = 32,
   parameter int SYNC_STAGES = 2    // must be >= 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tx_load,
   input  logic [SPI_MAXLEN-1:0]        tx_data,
   input  logic [$clog2(SPI_MAXLEN):0]  tx_nbits,
   output logic [SPI_MAXLEN-1:0]        rx_data,
   output logic [$clog2(SPI_MAXLEN):0]  rx_nbits,
   output logic                         rx_valid,
   input  logic                         rx_ack,
   output logic                         busy,
   input  logic                         SCLK,
   input  logic                         MOSI,
   input  logic                         SS_N,
`ifdef SPI_SLAVE_OVERRUN_EN
   output logic                         rx_overrun,
`endif
   output logic                         MISO
);

   localparam int NW = $clog2(SPI_MAXLEN) + 1;
   localparam logic [NW-1:0] MAXLEN_N = NW'(SPI_MAXLEN);
   localparam logic [7:0]    FLUSH_N  = 8'(SYNC_STAGES);

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      ACTIVE    = 2'd2
   } state_t;

   // Current FSM state, visible by hierarchical reference for debug.
   state_t state;

   // ---------------- synchronisers and edge detect ----------------
   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
   logic                   sclk_prev, ss_prev;
   logic                   sclk_s, mosi_s, ss_s;
   logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_sync   <= '1;
         sclk_prev <= 1'b0;
         ss_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_N};
         sclk_prev <= sclk_s;
         ss_prev   <= ss_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s &  sclk_prev;
   assign ss_fall   = ~ss_s   &  ss_prev;
   assign ss_rise   =  ss_s   & ~ss_prev;

   // ---------------- TX alignment ----------------
   // The response is left-aligned into the shifter so the first bit sits in
   // the MSB. Each SCLK fall then shifts left, and zeros shift in behind.
   // Once the valid bits are used up, MISO therefore reads 0.
   // tx_nbits above SPI_MAXLEN is clamped.
   logic [SPI_MAXLEN-1:0] tx_buf_data;
   logic [NW-1:0]         tx_buf_nbits;
   logic [NW-1:0]         tx_eff, tx_sh;
   logic [SPI_MAXLEN-1:0] tx_aligned;

   assign tx_eff     = (tx_buf_nbits > MAXLEN_N) ? MAXLEN_N : tx_buf_nbits;
   assign tx_sh      = MAXLEN_N - tx_eff;
   assign tx_aligned = tx_buf_data << tx_sh;

   // ---------------- main FSM ----------------
   logic [SPI_MAXLEN-1:0] tx_shift;
   logic [SPI_MAXLEN-1:0] rx_shift;
   logic [NW-1:0]         rx_cnt;
   // WAIT_IDLE counts the synchroniser flush first, so the reset value
   // of ss_sync (1) cannot be mistaken for an idle bus.
   logic [7:0]            flush_cnt;
   logic                  miso_q;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic                  overrun_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= WAIT_IDLE;
         flush_cnt    <= '0;
         tx_buf_data  <= '0;
         tx_buf_nbits <= '0;
         tx_shift     <= '0;
         rx_shift     <= '0;
         rx_cnt       <= '0;
         rx_data      <= '0;
         rx_nbits     <= '0;
         rx_valid     <= 1'b0;
         busy         <= 1'b0;
         miso_q       <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
         overrun_q    <= 1'b0;
`endif
      end else begin
         if (tx_load) begin
            tx_buf_data  <= tx_data;
            tx_buf_nbits <= tx_nbits;
         end

         // Clear on ack. The frame-completion branch below assigns later,
         // so a coincident completion keeps the flags set.
         if (rx_ack) begin
            rx_valid  <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun_q <= 1'b0;
`endif
         end

         case (state)
            WAIT_IDLE: begin
               busy   <= 1'b0;
               miso_q <= 1'b0;
               if (flush_cnt != FLUSH_N)
                  flush_cnt <= flush_cnt + 8'd1;
               else if (ss_s)
                  state <= IDLE;
            end

            IDLE: begin
               if (ss_fall) begin
                  state    <= ACTIVE;
                  tx_shift <= tx_aligned;
                  miso_q   <= tx_aligned[SPI_MAXLEN-1];
                  busy     <= 1'b1;
                  rx_shift <= '0;
                  rx_cnt   <= '0;
               end
            end

            ACTIVE: begin
               // SS_N rise outranks any SCLK edge seen in the same cycle.
               if (ss_rise) begin
                  state    <= IDLE;
                  rx_data  <= rx_shift;
                  rx_nbits <= rx_cnt;
                  rx_valid <= 1'b1;
                  busy     <= 1'b0;
                  miso_q   <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
                  if (rx_valid && !rx_ack)
                     overrun_q <= 1'b1;
`endif
               end else if (sclk_rise) begin
                  rx_shift <= {rx_shift[SPI_MAXLEN-2:0], mosi_s};
                  if (rx_cnt != MAXLEN_N)
                     rx_cnt <= rx_cnt + 1'b1;
               end else if (sclk_fall) begin
                  tx_shift <= {tx_shift[SPI_MAXLEN-2:0], 1'b0};
                  miso_q   <= tx_shift[SPI_MAXLEN-2];
               end
            end

            default: state <= WAIT_IDLE;
         endcase
      end
   end

   assign MISO = miso_q;
`ifdef SPI_SLAVE_OVERRUN_EN
   assign rx_overrun = overrun_q;
`endif

endmodule
